ic_test_sequencer: RTL and testbench
====================================

// Module: ic_test_sequencer
// PURPOSE
//  Upstream driver of the gate-family select decoder. On start it drives select[2:0],
//  then steps exhaustively through input vectors for one gate of the chosen family.
//  Per vector it waits a settle time, samples the DUT output and checks it against an
//  internal golden model. It reports pass, or the first failing vector.
// PARAMETERS
//  SETTLE_CYCLES  8  clocks between stim change and sampling dut_resp; legal range 1..255
// PORTS
//  clk       in   1  single system clock, rising edge
//  rst_n     in   1  reset, asynchronous assert, active-low
//  start     in   1  1-cycle request; sampled only in IDLE
//  family    in   3  0=NOT(1 in), 1=TWO, 2=THREE, 3=FOUR, 4=EIGHT inputs; 5..7 illegal
//  gate_fn   in   2  0=AND 1=OR 2=NAND 3=NOR; ignored for NOT family
//  dut_resp  in   1  output pin of the gate under test, already synchronised upstream
//  select    out  3  to select decoder; 3'b111 = all family enables off
//  stim      out  8  DUT input pins; bits >= N are driven 0
//  busy      out  1  high from the cycle after start acceptance until DONE exits
//  done      out  1  1-cycle pulse at end of test
//  pass      out  1  result; valid from done pulse until next accepted start
//  fail_vec  out  8  first mismatching vector; 0 when pass=1
// BEHAVIOUR
//  Reset values: select=3'b111, stim=0, busy=0, done=0, pass=0, fail_vec=0, vec=0, state=IDLE.
//  Reset mid-test aborts immediately to these values; there is no resume.
//  N (input width) = 1/2/3/4/8 for family 0..4. Final vector = 2^N-1.
//  FSM IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE) -> IDLE.
//   IDLE: start=1 with family<=4: latch family and gate_fn, select<=family, vec<=0,
//         busy<=1, clear pass and fail_vec -> APPLY.
//         start=1 with family>=5: -> DONE with pass=0, fail_vec=0, select stays 111.
//   APPLY (1 clk): stim<=vec masked to N bits; settle counter<=SETTLE_CYCLES-1 -> SETTLE.
//   SETTLE: counts down to 0; on 0 -> CHECK. Total SETTLE_CYCLES clocks.
//   CHECK (1 clk): compare dut_resp with golden(vec).
//         mismatch -> fail_vec<=vec, pass<=0 -> DONE (abort on first failure).
//         match and vec==2^N-1 -> pass<=1 -> DONE.
//         match otherwise -> vec<=vec+1 -> APPLY.
//   DONE (1 clk): done=1, select<=111, stim<=0, busy<=0 -> IDLE.
//  Cost per vector = SETTLE_CYCLES+2 clocks. Full-pass latency from the start edge
//   = 2^N*(SETTLE_CYCLES+2)+2 clocks to the done pulse.
//  vec is 9 bits so the EIGHT-family terminal compare does not wrap. fail_vec = vec[7:0].
//  Golden model: NOT = ~v[0]; AND = &v[N-1:0]; OR = |v[N-1:0];
//   NAND and NOR are the complements of AND and OR.
//  start while busy is ignored. start in the same cycle as the DONE state is ignored.
//  family and gate_fn are sampled only on acceptance; later changes have no effect.
//  select changes only on acceptance and in DONE. It never glitches through other codes.
// STRUCTURE
//  Shared package ic_tester_pkg holds:
//   FAM_NOT..FAM_EIGHT = 3'b000..3'b100 and FAM_OFF = 3'b111;
//   GFN_AND/OR/NAND/NOR; the state encoding; a function mapping family -> N.
//  One combinational sub-module, ic_golden_model (family, gate_fn, vec -> expected),
//   is reused by the bench scoreboard.
// TESTING (SETTLE_CYCLES=8)
//  1. family=1, gate_fn=AND, ideal AND DUT -> stim visits 0..3; done at clock 42;
//     pass=1, fail_vec=0.
//  2. family=0, ideal inverter -> 2 vectors; done at clock 22; pass=1; select=000 while busy.
//  3. family=4, NOR DUT stuck-at-1 -> first mismatch at vec 1; pass=0, fail_vec=8'h01;
//     select returns to 111.
//  4. family=6 start -> done on the next cycle; pass=0; select stays 111; busy stays 0.
//  5. rst_n low during SETTLE of a family=3 test -> same cycle select=111, stim=0, busy=0.
//     A new start then begins at vec 0.
//  6. start pulses while busy, and family changed mid-test -> both ignored;
//     original test completes unchanged.

Source files
------------

// File: rtl/ic_tester_pkg.sv
// Shared definitions for the gate-family tester: family and gate-function codes,
// sequencer state encoding, and helpers that map a family to its input width.
package ic_tester_pkg;

  localparam logic [2:0] FAM_NOT   = 3'b000;
  localparam logic [2:0] FAM_TWO   = 3'b001;
  localparam logic [2:0] FAM_THREE = 3'b010;
  localparam logic [2:0] FAM_FOUR  = 3'b011;
  localparam logic [2:0] FAM_EIGHT = 3'b100;
  localparam logic [2:0] FAM_OFF   = 3'b111;

  localparam logic [1:0] GFN_AND  = 2'd0;
  localparam logic [1:0] GFN_OR   = 2'd1;
  localparam logic [1:0] GFN_NAND = 2'd2;
  localparam logic [1:0] GFN_NOR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Number of gate inputs for a family; illegal codes report zero inputs.
  function automatic logic [3:0] fam_width(input logic [2:0] family);
    case (family)
      FAM_NOT:   return 4'd1;
      FAM_TWO:   return 4'd2;
      FAM_THREE: return 4'd3;
      FAM_FOUR:  return 4'd4;
      FAM_EIGHT: return 4'd8;
      default:   return 4'd0;
    endcase
  endfunction

  // Low N bits set; doubles as the terminal vector 2^N-1.
  function automatic logic [7:0] fam_mask(input logic [2:0] family);
    logic [8:0] m;
    m = (9'd1 << fam_width(family)) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ic_golden_model.sv
// Combinational reference response of one gate of the selected family to an input
// vector; bits above the family width are ignored.
module ic_golden_model
  import ic_tester_pkg::*;
(
  input  logic [2:0] family,
  input  logic [1:0] gate_fn,
  input  logic [7:0] vec,
  output logic       expected
);

  logic [7:0] mask;
  logic [7:0] bits;
  logic       all_hi;
  logic       any_hi;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mask     = fam_mask(family);
    bits     = vec & mask;
    all_hi   = (bits == mask) && (mask != 8'd0);
    any_hi   = |bits;
    expected = 1'b0;
    if (family == FAM_NOT) begin
      expected = ~vec[0];
    end else if (mask != 8'd0) begin
      case (gate_fn)
        GFN_AND:  expected = all_hi;
        GFN_OR:   expected = any_hi;
        GFN_NAND: expected = ~all_hi;
        default:  expected = ~any_hi;
      endcase
    end
  end

endmodule

// File: rtl/ic_test_sequencer.sv
// Drives the family select decoder, steps exhaustively through input vectors of one
// gate, samples its response after a settle delay and reports pass or first failure.
module ic_test_sequencer
  import ic_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] family,
  input  logic [1:0] gate_fn,
  input  logic       dut_resp,
  output logic [2:0] select,
  output logic [7:0] stim,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state;
  logic [2:0] fam_q;
  logic [1:0] gfn_q;
  logic [8:0] vec;
  logic [7:0] cnt;
  logic [7:0] mask;
  logic       expected;

  assign mask = fam_mask(fam_q);

  ic_golden_model u_golden (
    .family   (fam_q),
    .gate_fn  (gfn_q),
    .vec      (vec[7:0]),
    .expected (expected)
  );

  // NOTE: all state and outputs use non-blocking assignments; done defaults low each
  // cycle so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fam_q    <= FAM_OFF;
      gfn_q    <= GFN_AND;
      vec      <= '0;
      cnt      <= '0;
      select   <= FAM_OFF;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass     <= 1'b0;
            fail_vec <= '0;
            if (family <= FAM_EIGHT) begin
              fam_q  <= family;
              gfn_q  <= gate_fn;
              select <= family;
              vec    <= '0;
              busy   <= 1'b1;
              state  <= ST_APPLY;
            end else begin
              state  <= ST_DONE;
            end
          end
        end
        ST_APPLY: begin
          stim  <= vec[7:0] & mask;
          cnt   <= SETTLE_LOAD;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == 8'd0) state <= ST_CHECK;
          else             cnt   <= cnt - 8'd1;
        end
        ST_CHECK: begin
          if (dut_resp != expected) begin
            fail_vec <= vec[7:0];
            pass     <= 1'b0;
            state    <= ST_DONE;
          end else if (vec == {1'b0, mask}) begin
            pass     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            vec      <= vec + 9'd1;
            state    <= ST_APPLY;
          end
        end
        ST_DONE: begin
          done   <= 1'b1;
          select <= FAM_OFF;
          stim   <= '0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed bench for ic_test_sequencer: an ideal or faulty gate is modelled around
// stim, and latency, verdict, visited vectors and select behaviour are checked.
module tb_ic_test_sequencer;
  import ic_tester_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] family = 3'd0;
  logic [1:0] gate_fn = 2'd0;
  logic       dut_resp;
  logic [2:0] select;
  logic [7:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_vec;

  int checks = 0;
  int failures = 0;

  logic [2:0] tb_fam = 3'd0;
  logic [1:0] tb_fn = 2'd0;
  int         resp_mode = 0;
  logic [7:0] stim_log[$];

  logic [2:0] g_fam;
  logic [1:0] g_fn;
  logic [7:0] g_vec;
  logic       g_exp;

  typedef struct {
    logic [2:0] f;
    logic [1:0] fn;
    logic [7:0] v;
    logic       e;
  } gv_t;

  gv_t gtbl[8];

  always #5 clk = ~clk;

  ic_test_sequencer #(.SETTLE_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .family   (family),
    .gate_fn  (gate_fn),
    .dut_resp (dut_resp),
    .select   (select),
    .stim     (stim),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_vec (fail_vec)
  );

  ic_golden_model u_gold (
    .family   (g_fam),
    .gate_fn  (g_fn),
    .vec      (g_vec),
    .expected (g_exp)
  );

  // Behaviour of a correct gate on its pins; upper pins must be driven 0 to reach all-ones.
  function automatic logic ideal_resp(input logic [2:0] f, input logic [1:0] fn,
                                      input logic [7:0] v);
    int   n;
    logic all1;
    logic any1;
    case (f)
      3'd0:    n = 1;
      3'd1:    n = 2;
      3'd2:    n = 3;
      3'd3:    n = 4;
      default: n = 8;
    endcase
    all1 = (int'(v) == (1 << n) - 1);
    any1 = (v != 8'd0);
    if (f == 3'd0) return ~v[0];
    case (fn)
      2'd0:    return all1;
      2'd1:    return any1;
      2'd2:    return ~all1;
      default: return ~any1;
    endcase
  endfunction

  always_comb dut_resp = (resp_mode == 1) ? 1'b1 : ideal_resp(tb_fam, tb_fn, stim);

  function automatic int seq_errs(input int n);
    int e;
    e = 0;
    if (stim_log.size() != n) e++;
    foreach (stim_log[i]) if (stim_log[i] !== 8'(i)) e++;
    return e;
  endfunction

  task automatic launch(input logic [2:0] f, input logic [1:0] fn, input int mode);
    @(negedge clk);
    tb_fam    = f;
    tb_fn     = fn;
    resp_mode = mode;
    family    = f;
    gate_fn   = fn;
    start     = 1'b1;
    stim_log.delete();
  endtask

  // Clock 1 is the acceptance edge; returns how many edges until done is seen high.
  task automatic run(input int limit, input bit disturb, input logic [2:0] exp_sel,
                     output int clocks, output bit seen, output int sel_errs,
                     output bit busy_seen, output logic pass_at_accept);
    clocks = 0; seen = 1'b0; sel_errs = 0; busy_seen = 1'b0; pass_at_accept = 1'bx;
    while (!seen && clocks < limit) begin
      @(posedge clk);
      clocks++;
      #1;
      if (clocks == 1) begin
        start = 1'b0;
        pass_at_accept = pass;
      end
      if (disturb && (clocks == 5 || clocks == 23)) begin
        start = 1'b1; family = 3'd3; gate_fn = GFN_NOR;
      end else if (disturb) begin
        start = 1'b0;
      end
      if (busy) begin
        busy_seen = 1'b1;
        if (stim_log.size() == 0 || stim_log[$] !== stim) stim_log.push_back(stim);
      end
      if (select !== (busy ? exp_sel : FAM_OFF)) sel_errs++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (select !== FAM_OFF) begin failures++; $display("FAIL reset_select got=%b exp=111", select); end
    checks++; if (stim !== 8'h00) begin failures++; $display("FAIL reset_stim got=%h exp=00", stim); end
    checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags busy/done/pass got=%b exp=000", {busy, done, pass}); end
    checks++; if (fail_vec !== 8'h00) begin failures++; $display("FAIL reset_fail_vec got=%h exp=00", fail_vec); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden_model;
    gtbl[0] = '{3'd4, GFN_AND,  8'hFF, 1'b1};
    gtbl[1] = '{3'd4, GFN_AND,  8'hFE, 1'b0};
    gtbl[2] = '{3'd2, GFN_NOR,  8'h00, 1'b1};
    gtbl[3] = '{3'd3, GFN_OR,   8'h08, 1'b1};
    gtbl[4] = '{3'd2, GFN_OR,   8'h08, 1'b0};
    gtbl[5] = '{3'd1, GFN_NAND, 8'h03, 1'b0};
    gtbl[6] = '{3'd0, GFN_AND,  8'h01, 1'b0};
    gtbl[7] = '{3'd1, GFN_AND,  8'h07, 1'b1};
    foreach (gtbl[i]) begin
      g_fam = gtbl[i].f; g_fn = gtbl[i].fn; g_vec = gtbl[i].v;
      #1;
      checks++;
      if (g_exp !== gtbl[i].e) begin
        failures++;
        $display("FAIL golden_%0d fam=%0d fn=%0d vec=%h got=%b exp=%b",
                 i, gtbl[i].f, gtbl[i].fn, gtbl[i].v, g_exp, gtbl[i].e);
      end
    end
  endtask

  task automatic test_two_input_and(input bit disturb, input string tag);
    int clocks, sel_errs; bit seen, busy_seen; logic pa;
    launch(3'd1, GFN_AND, 0);
    run(400, disturb, 3'd1, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (!seen || clocks != 42) begin failures++; $display("FAIL %s_latency got=%0d seen=%0b exp=42", tag, clocks, seen); end
    checks++; if (pass !== 1'b1 || fail_vec !== 8'h00) begin failures++; $display("FAIL %s_verdict pass=%b fail_vec=%h exp pass=1 fail_vec=00", tag, pass, fail_vec); end
    checks++; if (seq_errs(4) != 0) begin failures++; $display("FAIL %s_stim_seq got %0d vectors, exp 0..3", tag, stim_log.size()); end
    checks++; if (sel_errs != 0) begin failures++; $display("FAIL %s_select got %0d bad cycles exp 0", tag, sel_errs); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s_done_pulse done=%b busy=%b exp 0 0", tag, done, busy); end
    family = 3'd0; gate_fn = 2'd0;
  endtask

  task automatic test_inverter;
    int clocks, sel_errs; bit seen, busy_seen; logic pa;
    launch(FAM_NOT, GFN_AND, 0);
    run(400, 1'b0, FAM_NOT, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (!seen || clocks != 22) begin failures++; $display("FAIL not_latency got=%0d seen=%0b exp=22", clocks, seen); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL not_pass got=%b exp=1", pass); end
    checks++; if (seq_errs(2) != 0) begin failures++; $display("FAIL not_stim_seq got %0d vectors exp 0..1", stim_log.size()); end
    checks++; if (sel_errs != 0 || !busy_seen) begin failures++; $display("FAIL not_select bad=%0d busy_seen=%0b exp 0 1", sel_errs, busy_seen); end
  endtask

  task automatic test_nor_stuck;
    int clocks, sel_errs; bit seen, busy_seen; logic pa;
    launch(FAM_EIGHT, GFN_NOR, 1);
    run(400, 1'b0, FAM_EIGHT, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (pa !== 1'b0) begin failures++; $display("FAIL nor_pass_cleared got=%b exp=0", pa); end
    checks++; if (!seen || clocks != 22) begin failures++; $display("FAIL nor_latency got=%0d seen=%0b exp=22", clocks, seen); end
    checks++; if (pass !== 1'b0 || fail_vec !== 8'h01) begin failures++; $display("FAIL nor_verdict pass=%b fail_vec=%h exp pass=0 fail_vec=01", pass, fail_vec); end
    checks++; if (seq_errs(2) != 0) begin failures++; $display("FAIL nor_stim_seq got %0d vectors exp 0..1", stim_log.size()); end
    checks++; if (sel_errs != 0 || select !== FAM_OFF || stim !== 8'h00) begin failures++; $display("FAIL nor_release bad=%0d select=%b stim=%h exp 0 111 00", sel_errs, select, stim); end
  endtask

  task automatic test_illegal_family;
    int clocks, sel_errs; bit seen, busy_seen; logic pa;
    launch(3'd6, GFN_AND, 0);
    run(50, 1'b0, FAM_OFF, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (!seen || clocks != 2) begin failures++; $display("FAIL illegal_latency got=%0d seen=%0b exp=2", clocks, seen); end
    checks++; if (pass !== 1'b0 || fail_vec !== 8'h00) begin failures++; $display("FAIL illegal_verdict pass=%b fail_vec=%h exp 0 00", pass, fail_vec); end
    checks++; if (busy_seen || sel_errs != 0) begin failures++; $display("FAIL illegal_idle busy_seen=%0b bad_select=%0d exp 0 0", busy_seen, sel_errs); end
  endtask

  task automatic test_reset_mid;
    int clocks, sel_errs; bit seen, busy_seen; logic pa;
    launch(FAM_FOUR, GFN_AND, 0);
    run(4, 1'b0, FAM_FOUR, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (busy !== 1'b1 || select !== FAM_FOUR) begin failures++; $display("FAIL mid_running busy=%b select=%b exp 1 011", busy, select); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (select !== FAM_OFF || stim !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL mid_abort select=%b stim=%h busy=%b exp 111 00 0", select, stim, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    launch(FAM_FOUR, GFN_OR, 0);
    run(400, 1'b0, FAM_FOUR, clocks, seen, sel_errs, busy_seen, pa);
    checks++; if (!seen || clocks != 162) begin failures++; $display("FAIL restart_latency got=%0d seen=%0b exp=162", clocks, seen); end
    checks++; if (seq_errs(16) != 0 || pass !== 1'b1) begin failures++; $display("FAIL restart_from_zero vectors=%0d pass=%b exp 16 1", stim_log.size(), pass); end
  endtask

  initial begin
    test_reset();
    test_golden_model();
    test_two_input_and(1'b0, "and2");
    test_inverter();
    test_nor_stuck();
    test_illegal_family();
    test_reset_mid();
    test_two_input_and(1'b1, "ignored_start");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
